// File: rtl/fifo_burst_reader.sv
// Drain stage for fifo_mem: pulls threshold-triggered bursts (or timeout single-beat
// flushes) out of the FIFO and presents them on a valid/ready stream with a last marker.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_threshold,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  burst_done,
    output logic [CNT_WIDTH-1:0]  burst_count,
    output logic                  err_underrun
);

    localparam int ISS_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [ISS_W-1:0] BURST_LEN_V  = ISS_W'(BURST_LEN);
    localparam logic [ISS_W-1:0] BURST_LAST_V = ISS_W'(BURST_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST_V   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BURST, SINGLE, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [ISS_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [TMR_W-1:0]      idle_timer_q, idle_timer_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [1:0]            buf_last_q, buf_last_d;
    logic [1:0]            buf_wr;
    logic                  head_q, head_d;
    logic [1:0]            occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  burst_count_q, burst_count_d;
    logic                  err_q, err_d;

    logic       reading;
    logic       owed;
    logic       pop;
    logic       accept_last;
    logic       rd_last;
    logic       tail;
    logic [1:0] pending;

    assign m_valid      = (occ_q != 2'd0);
    assign m_data       = buf_data_q[head_q];
    assign m_last       = buf_last_q[head_q];
    assign pop          = m_valid & m_ready;
    assign accept_last  = pop & m_last;
    assign burst_done   = accept_last;
    assign busy         = (state_q != IDLE) || (occ_q != 2'd0);
    assign burst_count  = burst_count_q;
    assign err_underrun = err_q;

    // Read issue: never let buffered + in-flight words exceed the 2-entry buffer.
    always_comb begin
        reading = (state_q == BURST) || (state_q == SINGLE);
        owed    = 1'b0;
        case (state_q)
            BURST:   owed = (issue_cnt_q < BURST_LEN_V);
            SINGLE:  owed = (issue_cnt_q == '0);
            default: owed = 1'b0;
        endcase
        pending = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        fifo_rd = reading & owed & ~fifo_empty & (pending < 2'd2);
        rd_last = (state_q == SINGLE) || (issue_cnt_q == BURST_LAST_V);
    end

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        idle_timer_d = '0;
        case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                if (fifo_threshold) begin
                    state_d = BURST;
                end else if (!fifo_empty && idle_timer_q == TMR_LAST_V) begin
                    state_d = SINGLE;
                end else if (!fifo_empty) begin
                    idle_timer_d = idle_timer_q + 1'b1;
                end
            end
            BURST: begin
                if (fifo_rd) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == BURST_LAST_V) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            SINGLE: begin
                if (fifo_rd) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (accept_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured word lands behind the head; occ <= 1 whenever a capture is due.
    assign tail            = head_q ^ occ_q[0];
    assign inflight_d      = fifo_rd;
    assign inflight_last_d = fifo_rd & rd_last;
    assign head_d          = head_q ^ pop;
    assign occ_d           = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign burst_count_d   = burst_count_q + CNT_WIDTH'(accept_last);
    assign err_d           = err_q | (reading & owed & fifo_empty);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign buf_wr[gi]     = inflight_q & (tail == 1'(gi));
            assign buf_data_d[gi] = buf_wr[gi] ? fifo_data : buf_data_q[gi];
            assign buf_last_d[gi] = buf_wr[gi] ? inflight_last_q : buf_last_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            issue_cnt_q     <= '0;
            idle_timer_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q      <= '0;
            head_q          <= 1'b0;
            occ_q           <= '0;
            burst_count_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            issue_cnt_q     <= issue_cnt_d;
            idle_timer_q    <= idle_timer_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
            end
            buf_last_q      <= buf_last_d;
            head_q          <= head_d;
            occ_q           <= occ_d;
            burst_count_q   <= burst_count_d;
            err_q           <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small behavioural model of fifo_mem.
module tb_fifo_burst_reader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          thr = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          burst_done;
    logic [7:0]    burst_count;
    logic          err_underrun;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (8),
        .TIMEOUT   (32),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd       (fifo_rd),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_threshold(thr),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .burst_done    (burst_done),
        .burst_count   (burst_count),
        .err_underrun  (err_underrun)
    );

    // fifo_mem model: registered read, data valid the cycle after trans_read
    logic [DW-1:0] mem [0:63];
    int   wptr = 0;
    int   rptr = 0;
    logic fifo_clr = 1'b0;
    logic force_empty = 1'b0;

    assign fifo_empty = force_empty || (wptr == rptr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rptr <= wptr;
        end else if (fifo_rd && (wptr != rptr)) begin
            fifo_data <= mem[rptr[5:0]];
            rptr      <= rptr + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic push(input int v);
        mem[wptr[5:0]] = v[DW-1:0];
        wptr = wptr + 1;
    endtask

    task automatic clear_fifo();
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
    endtask

    logic [DW-1:0] bd [0:15];
    logic          bl [0:15];
    int            nb = 0;

    task automatic rec();
        if (m_valid && m_ready && nb < 16) begin
            bd[nb] = m_data;
            bl[nb] = m_last;
            $display("beat %0d data=%0d last=%0d", nb, m_data, m_last);
            nb++;
        end
    endtask

    task automatic check_beats(input string tag, input int n, input int base);
        chk($sformatf("%s beats", tag), nb, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s data%0d", tag, i), bd[i], base + i);
            chk($sformatf("%s last%0d", tag, i), bl[i], (i == n - 1));
        end
    endtask

    int nrd;
    int rdc [0:3];

    initial begin
        // Reset held with threshold high and a non-empty FIFO
        thr = 1'b1;
        for (int v = 1; v <= 9; v++) push(v);
        repeat (3) @(negedge clk);
        #1;
        chk("rst fifo_rd", fifo_rd, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst burst_count", burst_count, 0);
        chk("rst err", err_underrun, 0);
        @(negedge clk);
        thr = 1'b0;
        rst_n = 1'b1;
        clear_fifo();

        // Threshold burst with m_ready held high
        @(negedge clk);
        for (int v = 1; v <= 9; v++) push(v);
        thr = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("t1 idle rd", fifo_rd, 0);
        nb = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            thr = 1'b0;
            #1;
            rec();
            chk($sformatf("t1 rd k%0d", k), fifo_rd, (k <= 7));
            chk($sformatf("t1 valid k%0d", k), m_valid, (k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) begin
                chk($sformatf("t1 data k%0d", k), m_data, k - 1);
                chk($sformatf("t1 last k%0d", k), m_last, (k == 9));
            end
            chk($sformatf("t1 done k%0d", k), burst_done, (k == 9));
            if (k == 10) begin
                chk("t1 burst_count", burst_count, 1);
                chk("t1 busy", busy, 0);
                chk("t1 words left", wptr - rptr, 1);
            end
        end

        // Backpressure from the start of a burst
        clear_fifo();
        @(negedge clk);
        for (int v = 1; v <= 9; v++) push(v);
        thr = 1'b1;
        m_ready = 1'b0;
        nrd = 0;
        for (int j = 0; j <= 6; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 1) thr = 1'b0;
            #1;
            nrd += int'(fifo_rd);
            if (j == 3 || j == 6) begin
                chk($sformatf("t2 hold valid j%0d", j), m_valid, 1);
                chk($sformatf("t2 hold data j%0d", j), m_data, 1);
                chk($sformatf("t2 hold last j%0d", j), m_last, 0);
            end
        end
        chk("t2 reads under bp", nrd, 2);
        nb = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            rec();
            if (burst_done) break;
        end
        check_beats("t2", 8, 1);
        @(negedge clk);
        #1;
        chk("t2 burst_count", burst_count, 2);

        // Underrun after 5 reads
        clear_fifo();
        @(negedge clk);
        for (int v = 1; v <= 9; v++) push(v);
        thr = 1'b1;
        nrd = 0;
        nb = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            thr = 1'b0;
            #1;
            nrd += int'(fifo_rd);
            rec();
            if (nrd == 5) break;
        end
        chk("t3 reads before stall", nrd, 5);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            force_empty = 1'b1;
            #1;
            chk($sformatf("t3 stall rd j%0d", j), fifo_rd, 0);
            rec();
        end
        chk("t3 err_underrun", err_underrun, 1);
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            force_empty = 1'b0;
            #1;
            nrd += int'(fifo_rd);
            rec();
            if (burst_done) break;
        end
        chk("t3 total reads", nrd, 8);
        check_beats("t3", 8, 1);
        @(negedge clk);
        #1;
        chk("t3 burst_count", burst_count, 3);
        chk("t3 err sticky", err_underrun, 1);

        // Reset mid-burst after 4 accepted beats
        clear_fifo();
        @(negedge clk);
        for (int v = 1; v <= 9; v++) push(v);
        thr = 1'b1;
        nb = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            thr = 1'b0;
            #1;
            rec();
            if (nb == 4) break;
        end
        chk("t4 beats before reset", nb, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4 rst m_valid", m_valid, 0);
        chk("t4 rst fifo_rd", fifo_rd, 0);
        chk("t4 rst busy", busy, 0);
        chk("t4 rst burst_count", burst_count, 0);
        chk("t4 rst err", err_underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_fifo();
        @(negedge clk);
        for (int v = 21; v <= 29; v++) push(v);
        thr = 1'b1;
        nb = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            thr = 1'b0;
            #1;
            rec();
            if (burst_done) break;
        end
        check_beats("t4 fresh", 8, 21);
        @(negedge clk);
        #1;
        chk("t4 burst_count", burst_count, 1);

        // Timeout flush of a 3-word FIFO below threshold
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_fifo();
        nb = 0;
        nrd = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (c == 0) begin
                push(41);
                push(42);
                push(43);
            end
            #1;
            if (fifo_rd) begin
                if (nrd < 4) rdc[nrd] = c;
                nrd++;
            end
            rec();
        end
        chk("t5 reads", nrd, 3);
        chk("t5 rd cycle 0", rdc[0], 32);
        chk("t5 rd cycle 1", rdc[1], 67);
        chk("t5 rd cycle 2", rdc[2], 102);
        chk("t5 beats", nb, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5 data%0d", i), bd[i], 41 + i);
            chk($sformatf("t5 last%0d", i), bl[i], 1);
        end
        chk("t5 burst_count", burst_count, 3);
        chk("t5 busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Downstream drain stage for fifo_mem. It watches the FIFO's threshold and empty flags and issues trans_read pulses into the FIFO. It re-times the returned data_out words into a 2-entry output buffer and presents them as valid/ready bursts with a last marker. A partially filled FIFO that sits idle too long is flushed as single-beat bursts.

Parameters:
DATA_WIDTH, 16, width of FIFO word and output data
BURST_LEN, 8, beats per threshold-triggered burst; must be <= the FIFO THRESHOLD_VALUE
TIMEOUT, 32, idle cycles with FIFO non-empty and below threshold before a single-beat flush
CNT_WIDTH, 8, width of burst_count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fifo_rd  out  1  to fifo_mem trans_read; one word popped per cycle high
fifo_data  in  DATA_WIDTH  from fifo_mem data_out; valid the cycle after fifo_rd
fifo_empty  in  1  from fifo_mem empty_ind
fifo_threshold  in  1  from fifo_mem threshold_ind
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  output beat data
m_last  out  1  final beat of current burst
busy  out  1  state != IDLE or buffer non-empty
burst_done  out  1  one-cycle pulse when the m_last beat is accepted
burst_count  out  CNT_WIDTH  completed bursts, wraps at 2^CNT_WIDTH
err_underrun  out  1  sticky; set if fifo_empty is seen while a burst still owes reads

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Buffer emptied. Counters and timer 0. err_underrun cleared.
- FSM states: IDLE, BURST, SINGLE, WAIT_DONE.
- IDLE -> BURST when fifo_threshold=1. This has priority over the timeout.
- IDLE -> SINGLE when fifo_empty=0, fifo_threshold=0 and idle_timer == TIMEOUT-1.
- idle_timer increments in IDLE while fifo_empty=0. It clears on leaving IDLE or when fifo_empty=1.
- BURST: issue reads until issue_cnt == BURST_LEN, then go to WAIT_DONE.
- SINGLE: issue exactly one read, then go to WAIT_DONE.
- WAIT_DONE -> IDLE on the cycle the m_last beat is accepted (m_valid & m_ready & m_last).
- Read issue rule: fifo_rd = (state is BURST or SINGLE) & reads still owed & !fifo_empty & (occ + inflight - pop) < 2.
  - occ: buffer entries, 0..2.
  - inflight: reads issued whose data has not yet been captured, 0..1.
  - pop: m_valid & m_ready this cycle.
  - fifo_rd is a combinational function of registered state plus fifo_empty and m_ready.
- Capture: data is captured into the buffer at the end of the cycle after fifo_rd. The last-flag for each word is computed at issue time and stored with the word:
  - last = 1 when issue_cnt == BURST_LEN-1 in BURST;
  - last = 1 always in SINGLE.
- Latency: fifo_rd in cycle N -> m_valid with that word in cycle N+2 when the buffer was empty.
- Throughput: one beat per cycle is sustained with m_ready held 1.
- Buffer order: FIFO order. m_data/m_last come from the head entry. m_valid = occ>0.
- Handshake: m_data and m_last hold stable while m_valid=1 and m_ready=0. m_valid never drops without acceptance.
- Backpressure: with m_ready=0, at most 2 words are held (buffer plus in-flight). fifo_rd stays 0 until a pop. No word is dropped or duplicated.
- Simultaneous capture and pop in the same cycle: occ is unchanged and the head advances.
- Underrun: fifo_empty=1 in BURST with reads owed means fifo_rd=0 (stall) and err_underrun is set. The burst resumes when the FIFO is non-empty. The burst is never truncated.
- burst_done and the burst_count increment happen on the same cycle the m_last beat is accepted. burst_count wraps to 0 after its maximum.
- Reset mid-burst: immediate return to IDLE. Buffer and inflight are discarded. m_valid=0 asynchronously.

Test Plan:
- Reset: hold rst_n=0 with fifo_threshold=1 -> fifo_rd, m_valid, busy, burst_count, err_underrun all 0.
- Threshold burst, m_ready=1, FIFO holding 1..9, threshold rising at cycle T -> fifo_rd high T..T+7; m_valid high T+2..T+9 with data 1..8; m_last only on data 8; burst_done pulse at T+9; burst_count=1; word 9 stays in the FIFO.
- Backpressure: m_ready=0 from the start of a burst -> exactly 2 fifo_rd pulses then fifo_rd=0 and m_data=1 held stable. Release m_ready -> data 1..8 delivered in order, none lost.
- Timeout flush: 3 words in the FIFO, threshold=0, m_ready=1 -> after 32 idle cycles one single-beat burst (m_last=1), repeated every flush until the FIFO is empty; burst_count=3.
- Underrun: force fifo_empty=1 after 5 reads of a burst -> fifo_rd=0 and err_underrun=1. Deassert fifo_empty -> remaining 3 reads issue; m_last on beat 8.
- Reset mid-burst after 4 beats accepted -> m_valid=0 immediately, state IDLE. The next threshold assertion starts a fresh 8-beat burst.
